// File: rtl/dmadd_sequencer.sv
// Command sequencer for DMADD: buffers LOAD/RUN commands and drives the unit's pins one at a time.
// Optional `DMADD_SEQ_PERF_EN adds a saturating completed-RUN counter on run_count.
module dmadd_sequencer #(
   parameter int FIFO_DEPTH = 4,
   parameter int RUN_LAT    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_kind,
   input  logic [1:0]  cmd_insn,
   input  logic [3:0]  cmd_index,
   input  logic [3:0]  cmd_data,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [11:0] res_data,
   output logic        busy,
   output logic        dm_load,
   output logic        dm_run,
   output logic [1:0]  dm_insn,
   output logic [3:0]  dm_index,
   output logic [3:0]  dm_data,
   input  logic [7:0]  dm_out,
   input  logic [3:0]  dm_out_top,
   output logic [15:0] run_count
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int LAT_W = (RUN_LAT > 1) ? $clog2(RUN_LAT) : 1;

   typedef enum logic [2:0] {IDLE, LOAD, RUN, WAIT, RESP} state_t;

   state_t           state, state_nxt;
   logic [10:0]      mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;
   logic [10:0]      head;
   logic             full, empty, push, pop;
   logic [LAT_W-1:0] wait_cnt;

   assign full      = (count == CNT_W'(FIFO_DEPTH));
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign pop       = (state == IDLE) && !empty;
   assign head      = mem[rd_ptr];
   assign busy      = (state != IDLE) || !empty;

   // Command FIFO: pointers wrap naturally because the depth is a power of two
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cmd_kind, cmd_insn, cmd_index, cmd_data};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      dm_load   = 1'b0;
      dm_run    = 1'b0;
      res_valid = 1'b0;
      case (state)
         IDLE: if (!empty) state_nxt = head[10] ? RUN : LOAD;
         LOAD: begin
            dm_load   = 1'b1;
            state_nxt = IDLE;
         end
         RUN: begin
            dm_run    = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: if (wait_cnt == '0) state_nxt = RESP;
         RESP: begin
            res_valid = 1'b1;
            if (res_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Pin fields are latched at pop so they are already stable in the pulse cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         dm_insn  <= '0;
         dm_index <= '0;
         dm_data  <= '0;
         wait_cnt <= '0;
         res_data <= '0;
      end else begin
         if (pop) begin
            dm_insn  <= head[9:8];
            dm_index <= head[7:4];
            dm_data  <= head[3:0];
         end
         if (state == RUN)
            wait_cnt <= LAT_W'(RUN_LAT - 1);
         else if (state == WAIT && wait_cnt != '0)
            wait_cnt <= wait_cnt - LAT_W'(1);
         if (state == WAIT && wait_cnt == '0)
            res_data <= {dm_out_top, dm_out};
      end
   end

`ifdef DMADD_SEQ_PERF_EN
   logic [15:0] run_cnt_q;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst)                         run_cnt_q <= '0;
      else if (res_valid && res_ready) run_cnt_q <= sat_inc16(run_cnt_q);
   end

   assign run_count = run_cnt_q;
`else
   assign run_count = 16'h0000;
`endif

endmodule

// File: tb/tb_dmadd_sequencer.sv
// Randomised bench for dmadd_sequencer: a timeline/queue model predicts every output each cycle.
module tb_dmadd_sequencer;
   localparam int FIFO_DEPTH = 4;
   localparam int RUN_LAT    = 4;
   localparam int INF        = 32'h7fffffff;

   logic        clk = 0;
   logic        rst = 1;
   logic        cmd_valid = 0, cmd_kind = 0;
   logic [1:0]  cmd_insn = 0;
   logic [3:0]  cmd_index = 0, cmd_data = 0;
   logic [11:0] cmd_res = 0;
   logic        res_ready = 0;
   logic [7:0]  dm_out = 0;
   logic [3:0]  dm_out_top = 0;
   logic        cmd_ready, res_valid, busy, dm_load, dm_run;
   logic [11:0] res_data;
   logic [1:0]  dm_insn;
   logic [3:0]  dm_index, dm_data;
   logic [15:0] run_count;

   dmadd_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .RUN_LAT(RUN_LAT)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind),
      .cmd_insn(cmd_insn), .cmd_index(cmd_index), .cmd_data(cmd_data), .res_valid(res_valid),
      .res_ready(res_ready), .res_data(res_data), .busy(busy), .dm_load(dm_load), .dm_run(dm_run),
      .dm_insn(dm_insn), .dm_index(dm_index), .dm_data(dm_data), .dm_out(dm_out),
      .dm_out_top(dm_out_top), .run_count(run_count));

   always #5 clk = ~clk;

   typedef struct {
      logic        kind;
      logic [1:0]  insn;
      logic [3:0]  index;
      logic [3:0]  data;
      logic [11:0] res;
   } cmd_t;

   // Model: pending queue plus a timeline of when the sequencer is free / the result is due
   cmd_t        q[$];
   cmd_t        issue_cmd, last_cmd;
   int          cyc = 0, free_cyc = 0, due_cyc = 0;
   bit          pending = 0, issue_now = 0;
   logic [11:0] exp_res = 0;
   logic [15:0] model_cnt = 0;
   int          checks = 0, errors = 0;
   int          since = 100;
   logic [11:0] stub_res = 0;
   int          run_rise = -1, rv_rise = -1, loads_seen = 0, runs_seen = 0;
   logic        rv_prev = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      free_cyc  = 0;
      pending   = 0;
      last_cmd  = '{default: 0};
      issue_cmd = '{default: 0};
      model_cnt = 0;
      since     = 100;
   endtask

   task automatic tick();
      bit   push, pop, hs, idle, issue_next, exp_rv;
      cmd_t c;
      issue_next = 0;
      if (rst) begin
         model_reset();
      end else begin
         idle = (cyc >= free_cyc);
         push = cmd_valid && (q.size() < FIFO_DEPTH);
         pop  = idle && (q.size() > 0);
         hs   = res_ready && pending && (cyc >= due_cyc);
         if (hs) begin
            pending  = 0;
            free_cyc = cyc + 1;
            if (model_cnt != 16'hFFFF) model_cnt++;
         end
         if (pop) begin
            c = q.pop_front();
            issue_next = 1;
            issue_cmd  = c;
            last_cmd   = c;
            if (!c.kind) free_cyc = cyc + 2;
            else begin
               pending  = 1;
               exp_res  = c.res;
               due_cyc  = cyc + 2 + RUN_LAT;
               free_cyc = INF;
            end
         end
         if (push) begin
            c.kind = cmd_kind; c.insn = cmd_insn; c.index = cmd_index;
            c.data = cmd_data; c.res = cmd_res;
            q.push_back(c);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      issue_now = issue_next;
      // DMADD stand-in: the result is valid only exactly RUN_LAT cycles after the run pulse
      if (dm_run) begin since = 0; stub_res = issue_cmd.res; end
      else if (since < 100) since++;
      {dm_out_top, dm_out} = (since == RUN_LAT) ? stub_res : ~stub_res;
      if (dm_run) begin run_rise = cyc; runs_seen++; end
      if (dm_load) loads_seen++;
      if (res_valid && !rv_prev) rv_rise = cyc;
      rv_prev = res_valid;

      exp_rv = pending && (cyc >= due_cyc);
      chk("dm_load", 32'(dm_load), 32'(issue_now && !issue_cmd.kind));
      chk("dm_run", 32'(dm_run), 32'(issue_now && issue_cmd.kind));
      chk("dm_index", 32'(dm_index), 32'(last_cmd.index));
      if (issue_now && issue_cmd.kind)  chk("dm_insn", 32'(dm_insn), 32'(issue_cmd.insn));
      if (issue_now && !issue_cmd.kind) chk("dm_data", 32'(dm_data), 32'(issue_cmd.data));
      chk("res_valid", 32'(res_valid), 32'(exp_rv));
      if (exp_rv) chk("res_data", 32'(res_data), 32'(exp_res));
      chk("cmd_ready", 32'(cmd_ready), 32'(q.size() < FIFO_DEPTH));
      chk("busy", 32'(busy), 32'((cyc < free_cyc) || (q.size() > 0)));
`ifdef DMADD_SEQ_PERF_EN
      chk("run_count", 32'(run_count), 32'(model_cnt));
`else
      chk("run_count", 32'(run_count), 32'h0);
`endif
   endtask

   task automatic push_cmd(input logic k, input logic [1:0] i, input logic [3:0] x,
                           input logic [3:0] d, input logic [11:0] r);
      cmd_valid = 1; cmd_kind = k; cmd_insn = i; cmd_index = x; cmd_data = d; cmd_res = r;
      tick();
      cmd_valid = 0;
   endtask

   task automatic wait_res(input string name);
      bit ok = 0;
      for (int i = 0; i < 30 && !ok; i++) begin
         tick();
         if (res_valid) ok = 1;
      end
      if (!ok) chk(name, 32'(0), 32'(1));
   endtask

   task automatic wait_run(input string name);
      bit ok = 0;
      for (int i = 0; i < 30 && !ok; i++) begin
         tick();
         if (dm_run) ok = 1;
      end
      if (!ok) chk(name, 32'(0), 32'(1));
   endtask

   task automatic do_reset();
      rst = 1; tick(); tick(); rst = 0;
   endtask

   initial begin
      do_reset();
      chk("reset_cmd_ready", 32'(cmd_ready), 32'(1));
      chk("reset_busy", 32'(busy), 32'(0));
      tick();

      // LOAD idx=3 data=A
      push_cmd(0, 2'd0, 4'd3, 4'hA, 12'h0);
      tick();
      chk("load_pulse", 32'(dm_load), 32'(1));
      chk("load_index", 32'(dm_index), 32'(3));
      chk("load_data", 32'(dm_data), 32'hA);
      tick();
      chk("load_pulse_end", 32'(dm_load), 32'(0));
      chk("load_no_res", 32'(res_valid), 32'(0));

      // RUN insn=2 returning 12'h5C7
      res_ready = 1;
      run_rise = -1; rv_rise = -1;
      push_cmd(1, 2'd2, 4'd3, 4'd0, 12'h5C7);
      wait_res("run_timeout");
      chk("run_latency", 32'(rv_rise - run_rise), 32'(5));
      chk("run_result", 32'(res_data), 32'h5C7);
      tick();
      chk("run_res_drop", 32'(res_valid), 32'(0));

      // Reset in the middle of WAIT
      push_cmd(1, 2'd1, 4'd7, 4'd0, 12'hABC);
      wait_run("rst_run_timeout");
      tick(); tick();
      do_reset();
      chk("rst_dm_run", 32'(dm_run), 32'(0));
      chk("rst_dm_load", 32'(dm_load), 32'(0));
      chk("rst_res_valid", 32'(res_valid), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
      for (int i = 0; i < 8; i++) tick();

      // Fill the FIFO while the result port is stalled
      res_ready = 0;
      push_cmd(1, 2'd3, 4'd1, 4'd0, 12'h111);
      wait_res("fill_timeout");
      push_cmd(0, 2'd0, 4'd4, 4'h5, 12'h0);
      push_cmd(1, 2'd1, 4'd4, 4'h0, 12'h222);
      push_cmd(0, 2'd0, 4'd6, 4'h9, 12'h0);
      push_cmd(1, 2'd2, 4'd6, 4'h0, 12'h333);
      chk("full_cmd_ready", 32'(cmd_ready), 32'(0));
      push_cmd(0, 2'd0, 4'hF, 4'hF, 12'h0);
      loads_seen = 0; runs_seen = 0;
      res_ready = 1;
      for (int i = 0; i < 60; i++) tick();
      chk("drain_loads", 32'(loads_seen), 32'(2));
      chk("drain_runs", 32'(runs_seen), 32'(2));

      // Push and pop in the same cycle at occupancy 2
      res_ready = 0;
      push_cmd(1, 2'd0, 4'd2, 4'd0, 12'h444);
      wait_res("pp_timeout");
      push_cmd(0, 2'd0, 4'd8, 4'h1, 12'h0);
      push_cmd(0, 2'd0, 4'd9, 4'h2, 12'h0);
      res_ready = 1;
      tick();
      push_cmd(0, 2'd0, 4'hA, 4'h3, 12'h0);
      chk("pp_cmd_ready", 32'(cmd_ready), 32'(1));
      for (int i = 0; i < 20; i++) tick();

`ifdef DMADD_SEQ_PERF_EN
      do_reset();
      res_ready = 1;
      for (int n = 0; n < 3; n++) begin
         push_cmd(1, 2'(n), 4'(n), 4'd0, 12'(n * 33 + 5));
         for (int i = 0; i < 12; i++) tick();
      end
      chk("perf_count3", 32'(run_count), 32'(3));
      force dut.run_cnt_q = 16'hFFFF;
      model_cnt = 16'hFFFF;
      tick();
      release dut.run_cnt_q;
      push_cmd(1, 2'd1, 4'd1, 4'd0, 12'h777);
      for (int i = 0; i < 12; i++) tick();
      chk("perf_saturate", 32'(run_count), 32'hFFFF);
`else
      chk("perf_off", 32'(run_count), 32'h0);
`endif

      // Randomised traffic with occasional resets
      for (int i = 0; i < 4000; i++) begin
         cmd_valid = 1'($urandom_range(0, 1));
         cmd_kind  = 1'($urandom_range(0, 1));
         cmd_insn  = 2'($urandom);
         cmd_index = 4'($urandom);
         cmd_data  = 4'($urandom);
         cmd_res   = 12'($urandom);
         res_ready = ($urandom_range(0, 2) != 0);
         rst       = ($urandom_range(0, 599) == 0);
         tick();
      end
      rst = 0; cmd_valid = 0; res_ready = 1;
      for (int i = 0; i < 60; i++) tick();
      chk("final_idle", 32'(busy), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
